param_fifo: RTL

PARAM_FIFO -- requirements
Module: param_fifo

---
 rtl/param_fifo_if.sv | 37 +++
 rtl/param_fifo.sv | 119 +++++++++++
 2 files changed

// File: rtl/param_fifo_if.sv
// Handshake and status bundle for param_fifo: write/read requests, data,
// occupancy, status flags and sticky error flags.
interface param_fifo_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic             flush;
  logic             wr_en;
  logic [WIDTH-1:0] din;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             dout_valid;
  logic [CW-1:0]    count;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic             overflow;
  logic             underflow;
  logic             clr_err;

  // FIFO side
  modport slave (
    input  flush, wr_en, din, rd_en, clr_err,
    output dout, dout_valid, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );

  // Producer/consumer side
  modport master (
    output flush, wr_en, din, rd_en, clr_err,
    input  dout, dout_valid, count, empty, full,
           almost_empty, almost_full, overflow, underflow
  );
endinterface

// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with configurable depth/width, registered or
// first-word-fall-through read, threshold flags and sticky error flags.
module param_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AF_THRESH = DEPTH - 4,
  parameter int unsigned AE_THRESH = 4
) (
  input  logic          clk,
  input  logic          rst,
  param_fifo_if.slave   bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_empty;
  logic             r_full;
  logic             r_almost_empty;
  logic             r_almost_full;
  logic             r_overflow;
  logic             r_underflow;

  logic             w_rd_ok;
  logic             w_wr_ok;
  logic             w_ovf_evt;
  logic             w_unf_evt;
  logic [CW-1:0]    w_count_nxt;

  // Accept logic; flush masks both requests and any error events that cycle.
  always_comb begin
    w_rd_ok     = bus.rd_en && !r_empty && !bus.flush;
    w_wr_ok     = bus.wr_en && (!r_full || w_rd_ok) && !bus.flush;
    w_ovf_evt   = bus.wr_en && !w_wr_ok && !bus.flush;
    w_unf_evt   = bus.rd_en && r_empty && !bus.flush;
    w_count_nxt = r_count;
    if (bus.flush) begin
      w_count_nxt = '0;
    end else if (w_wr_ok && !w_rd_ok) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_rd_ok && !w_wr_ok) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  // Pointers, occupancy and flags; flags are a registered image of the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_count        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_empty <= 1'b1;
      r_almost_full  <= 1'b0;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      if (bus.flush) begin
        r_wr_ptr <= '0;
        r_rd_ptr <= '0;
      end else begin
        if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count        <= w_count_nxt;
      r_empty        <= (w_count_nxt == '0);
      r_full         <= (w_count_nxt == CW'(DEPTH));
      r_almost_empty <= (32'(w_count_nxt) <= AE_THRESH);
      r_almost_full  <= (32'(w_count_nxt) >= AF_THRESH);
      // A new error event wins over a simultaneous clear.
      r_overflow     <= w_ovf_evt || (r_overflow  && !bus.clr_err);
      r_underflow    <= w_unf_evt || (r_underflow && !bus.clr_err);
    end
  end

  // Storage is never cleared; reset only drops the write in flight.
  always_ff @(posedge clk) begin
    if (w_wr_ok && !rst) r_mem[r_wr_ptr] <= bus.din;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      assign bus.dout       = r_mem[r_rd_ptr];
      assign bus.dout_valid = !r_empty;
    end else begin : g_std
      logic [WIDTH-1:0] r_dout;
      logic             r_dout_valid;

      // One-cycle read latency; dout holds its last word between reads.
      always_ff @(posedge clk) begin
        if (rst) begin
          r_dout       <= '0;
          r_dout_valid <= 1'b0;
        end else begin
          r_dout_valid <= w_rd_ok;
          if (w_rd_ok) r_dout <= r_mem[r_rd_ptr];
        end
      end

      assign bus.dout       = r_dout;
      assign bus.dout_valid = r_dout_valid;
    end
  endgenerate

  assign bus.count        = r_count;
  assign bus.empty        = r_empty;
  assign bus.full         = r_full;
  assign bus.almost_empty = r_almost_empty;
  assign bus.almost_full  = r_almost_full;
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

endmodule
